// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared state encoding and line levels for the FIFO-draining UART transmitter
package uart_tx_pkg;

    // PARITY keeps its encoding even when the parity option is not built in
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, PARITY, STOP} tx_state_t;

    localparam logic TX_IDLE_LEVEL  = 1'b1;
    localparam logic TX_START_LEVEL = 1'b0;
    localparam logic TX_STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period counter, 0..CLKS_PER_BIT-1, with sync clear and end-of-bit flag
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic bit_end
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign bit_end = (cnt_q == LAST);

    // wrap at the end of each bit period so the next bit starts from zero
    always_comb cnt_d = (clr || bit_end) ? '0 : cnt_q + 1'b1;

    // counter register
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops words from a sync FIFO and sends them as UART frames; UART_PARITY_EN adds an even-parity bit
module fifo_uart_tx
    import uart_tx_pkg::*;
#(
    parameter int N            = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_en,
    input  logic [N-1:0]     fifo_data,
    input  logic             fifo_empty,
    output logic             fifo_rd,
    output logic             tx,
    output logic             busy,
    output logic             frame_done,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int BW = (N > 1) ? $clog2(N) : 1;

    tx_state_t        state_q, state_d;
    logic [N-1:0]     shift_q, shift_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bit_end, clr, last_bit;

    // the baud counter is held at zero until START so every bit period is full length
    assign clr      = (state_q == IDLE) || (state_q == FETCH) || (state_q == LOAD);
    assign last_bit = (bit_q == BW'(N - 1));

    uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .bit_end (bit_end)
    );

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (tx_en && !fifo_empty) state_d = FETCH;
            FETCH:   state_d = LOAD;
            LOAD:    state_d = START;
            START:   if (bit_end) state_d = DATA;
`ifdef UART_PARITY_EN
            DATA:    if (bit_end && last_bit) state_d = PARITY;
            PARITY:  if (bit_end) state_d = STOP;
`else
            DATA:    if (bit_end && last_bit) state_d = STOP;
`endif
            STOP:    if (bit_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // word capture in LOAD, LSB-first shifting, bit index and completed-frame count
    always_comb begin
        shift_d = (state_q == LOAD) ? fifo_data :
                  (state_q == DATA && bit_end) ? shift_q >> 1 : shift_q;
        bit_d   = (state_q == DATA && bit_end) ? (last_bit ? '0 : bit_q + 1'b1) : bit_q;
        cnt_d   = (state_q == STOP && bit_end) ? cnt_q + 1'b1 : cnt_q;
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
        end

`ifdef UART_PARITY_EN
    logic par_q, par_d;

    // even parity of the word, taken at capture time
    always_comb par_d = (state_q == LOAD) ? ^fifo_data : par_q;

    // parity register
    always_ff @(posedge clk or negedge rst)
        if (!rst) par_q <= 1'b0;
        else      par_q <= par_d;

    // line level decoded from state only
    always_comb
        tx = (state_q == START)  ? TX_START_LEVEL :
             (state_q == DATA)   ? shift_q[0] :
             (state_q == PARITY) ? par_q :
             (state_q == STOP)   ? TX_STOP_LEVEL : TX_IDLE_LEVEL;
`else
    // line level decoded from state only
    always_comb
        tx = (state_q == START) ? TX_START_LEVEL :
             (state_q == DATA)  ? shift_q[0] :
             (state_q == STOP)  ? TX_STOP_LEVEL : TX_IDLE_LEVEL;
`endif

    assign fifo_rd    = (state_q == FETCH);
    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == STOP) && bit_end;
    assign frame_cnt  = cnt_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: table-driven frame checks plus flow-control, wrap and async-reset sequences
module tb_fifo_uart_tx;

    localparam int CPB = 4;
`ifdef UART_PARITY_EN
    localparam int  NB  = 11;
    localparam bit  PAR = 1'b1;
`else
    localparam int  NB  = 10;
    localparam bit  PAR = 1'b0;
`endif

    localparam int M_ONE = 0, M_BB1 = 1, M_BB2 = 2, M_HOLD = 3, M_DROP = 4, M_RES = 5;

    typedef struct {
        logic [7:0] data;
        logic [9:0] seq;
        logic       par;
        logic [1:0] cnt;
        int         mode;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, tx_en;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_empty, fifo_rd, tx, busy, frame_done;
    logic [1:0] frame_cnt;

    logic [7:0] mem [16];
    int         wp = 0, rp = 0, underflow = 0;
    int         passed = 0, total = 0;
    vec_t       v [6];

    fifo_uart_tx #(.N(8), .CLKS_PER_BIT(CPB), .CNT_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_en      (tx_en),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_rd    (fifo_rd),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (wp == rp);

    always @(posedge clk)
        if (fifo_rd) begin
            if (wp == rp) underflow <= underflow + 1;
            else begin
                fifo_data <= mem[rp % 16];
                rp        <= rp + 1;
            end
        end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic push(input logic [7:0] d);
        mem[wp % 16] = d;
        wp++;
    endtask

    task automatic quiet(input int n, output logic rd_seen, output logic tx_low);
        rd_seen = 1'b0;
        tx_low  = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (fifo_rd) rd_seen = 1'b1;
            if (!tx) tx_low = 1'b1;
        end
    endtask

    task automatic run_frame(input int i, input int drop_at, output int waited);
        logic exp_bit, bad, done_bad;
        waited   = 0;
        done_bad = 1'b0;
        do begin
            @(negedge clk);
            waited++;
        end while (!fifo_rd && waited < 200);
        chk("fetch", fifo_rd, 1);
        chk("fetch_tx_high", tx, 1);
        @(negedge clk);
        chk("rd_pulse_width", fifo_rd, 0);
        chk("load_tx_high", tx, 1);
        for (int b = 0; b < NB; b++) begin
            exp_bit = (b < 9) ? v[i].seq[b] : (PAR && b == 9) ? v[i].par : 1'b1;
            bad     = 1'b0;
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                if (tx !== exp_bit) bad = 1'b1;
                if (frame_done !== (b == NB - 1 && c == CPB - 1)) done_bad = 1'b1;
                if (b * CPB + c == drop_at) tx_en = 1'b0;
            end
            chk($sformatf("frame%0d_bit%0d", i, b), bad, 0);
        end
        chk("frame_done_timing", done_bad, 0);
        @(negedge clk);
        chk("idle_after_frame", busy, 0);
        chk("frame_cnt", frame_cnt, v[i].cnt);
    endtask

    initial begin
        int   w;
        logic rd_seen, tx_low;
        v[0] = '{8'hA5, 10'b1_10100101_0, 1'b0, 2'd1, M_ONE};
        v[1] = '{8'h01, 10'b1_00000001_0, 1'b1, 2'd2, M_BB1};
        v[2] = '{8'hFF, 10'b1_11111111_0, 1'b0, 2'd3, M_BB2};
        v[3] = '{8'h07, 10'b1_00000111_0, 1'b1, 2'd0, M_HOLD};
        v[4] = '{8'h3C, 10'b1_00111100_0, 1'b0, 2'd1, M_DROP};
        v[5] = '{8'h00, 10'b1_00000000_0, 1'b0, 2'd2, M_RES};

        rst   = 1'b0;
        tx_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_fifo_rd", fifo_rd, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        rst = 1'b1;

        tx_en = 1'b1;
        quiet(100, rd_seen, tx_low);
        chk("empty_no_rd", rd_seen, 0);
        chk("empty_tx_high", tx_low, 0);

        for (int i = 0; i < 6; i++) begin
            case (v[i].mode)
                M_ONE: begin
                    push(v[i].data);
                    tx_en = 1'b1;
                    run_frame(i, -1, w);
                end
                M_BB1: begin
                    push(v[i].data);
                    push(v[i + 1].data);
                    tx_en = 1'b1;
                    run_frame(i, -1, w);
                end
                M_BB2: begin
                    run_frame(i, -1, w);
                    chk("b2b_gap", w, 1);
                end
                M_HOLD: begin
                    tx_en = 1'b0;
                    push(v[i].data);
                    quiet(100, rd_seen, tx_low);
                    chk("hold_no_rd", rd_seen, 0);
                    chk("hold_tx_high", tx_low, 0);
                    tx_en = 1'b1;
                    run_frame(i, -1, w);
                end
                M_DROP: begin
                    push(v[i].data);
                    push(v[i + 1].data);
                    tx_en = 1'b1;
                    run_frame(i, 13, w);
                    quiet(50, rd_seen, tx_low);
                    chk("drop_no_fetch", rd_seen, 0);
                    chk("drop_word_kept", wp - rp, 1);
                end
                M_RES: begin
                    tx_en = 1'b1;
                    run_frame(i, -1, w);
                end
                default: ;
            endcase
        end

        push(8'h00);
        tx_en = 1'b1;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!fifo_rd && w < 200);
        chk("rst_test_fetch", fifo_rd, 1);
        repeat (1 + CPB + CPB + 1) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_tx_low", tx, 0);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_tx", tx, 1);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_fifo_rd", fifo_rd, 0);
        chk("async_rst_frame_cnt", frame_cnt, 0);
        tx_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        quiet(20, rd_seen, tx_low);
        chk("post_rst_no_rd", rd_seen, 0);
        chk("post_rst_tx_high", tx_low, 0);
        chk("no_underflow", underflow, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
